card_dealer: RTL and testbench
==============================

# card_dealer

Card source for the two-slot matching game. It drives the colour/number card pairs (c1/n1, c2/n2) that the answer checker reads, and deals a new card into alternating slots on a fixed period. A pause input freezes the table while the player is keying an answer. Sits between game control and the checker.

## Interface
- DEAL_PERIOD, 15: cycles between consecutive deals; legal range 2..255
- SEED, 8'hA5: LFSR reset value; must be non-zero (used only with `DEALER_LFSR_EN`)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; sampled on clk
- start  in  1  level; begins dealing from IDLE
- stop  in  1  level; aborts dealing and clears the table
- hold  in  1  level; freezes the deal timer and all cards
- c1  out  2  slot-1 colour; 2'b00 = empty, 2'b01..2'b11 = colours
- n1  out  3  slot-1 number; 3'b000 = empty, 1..5 = values
- c2  out  2  slot-2 colour, same encoding as c1
- n2  out  3  slot-2 number, same encoding as n1
- new_card  out  1  one-cycle pulse in the cycle a card output changes
- slot  out  1  slot written by the last deal (0 = slot 1, 1 = slot 2)
- deal_cnt  out  8  cards dealt since start; saturates at 255

## Operation
- States: IDLE, DEAL, WAIT, PAUSE.
- IDLE: all cards are empty. If `start`=1 and `stop`=0, go to DEAL.
- DEAL: one cycle. Writes card k into slot (k mod 2): even k goes to slot 1, odd k to slot 2. Pulses `new_card`, increments `deal_cnt`, reloads the timer to DEAL_PERIOD-1, then goes to WAIT.
- WAIT: the timer decrements each cycle. When the timer reaches 0, go to DEAL. If `hold`=1, go to PAUSE instead.
- PAUSE: the timer is frozen and no deal occurs. When `hold`=0, return to WAIT with the timer value preserved.
- A deal that falls due in the same cycle `hold` rises is deferred. It happens on the first cycle after `hold` falls.
- `stop`=1 in any state:
  - next state is IDLE
  - cards, `slot`, `deal_cnt` and k are cleared
  - `stop` has priority over `start`, `hold` and a due deal
- The new card replaces the older of the two cards; the other slot is untouched.
- Card generation, default (no macro):
  - colour = (k mod 3)+1
  - number = (k mod 5)+1
  - k is an internal counter that wraps mod 15.
- With `DEALER_LFSR_EN`, cards come from the LFSR (see Configuration).
- `deal_cnt` holds at 255; k continues to wrap independently of it.

## Timing
- All outputs are registered.
- Reset values: c1=c2=0, n1=n2=0, new_card=0, slot=0, deal_cnt=0; state IDLE; LFSR=SEED.
- If `rst`=0 mid-operation, all outputs take their reset values at the next edge, with no partial deal.
- `start` seen at edge t:
  - first card visible after edge t+1
  - subsequent deals every DEAL_PERIOD edges (t+1+DEAL_PERIOD, ...)
- `hold` high for H cycles during WAIT delays all following deals by exactly H cycles.
- `new_card` is asserted only in the cycle after a DEAL edge; never twice in consecutive cycles.
- Cards are stable for at least DEAL_PERIOD cycles, so the checker may sample them freely while `new_card`=0.

## Configuration
- `DEALER_LFSR_EN` defined:
  - an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifts every cycle while not in IDLE
  - at DEAL: colour = (L[1:0]==0) ? 2'b01 : L[1:0]
  - v = L[4:2]; number = (v<5) ? v+1 : v-4
  - the LFSR reloads SEED on reset and on `stop`
- Undefined: the deterministic mod-3/mod-5 sequence; no LFSR logic is synthesised.

## Test plan
- Reset then start, DEAL_PERIOD=15, no macro; `start` at edge 0:
  - edge 1: c1=01, n1=001, slot=0, new_card pulse
  - edge 16: c2=10, n2=010, slot=1
  - edge 31: c1=11, n1=011, c2/n2 unchanged
- Hold: `hold`=1 for 10 cycles starting 5 cycles after card 0 -> card 1 appears at edge 26, not 16; no new_card pulse while held.
- Stop priority: `stop`=1 and `start`=1 together mid-WAIT -> next edge all cards 0, deal_cnt=0, IDLE; after `stop` falls, the first card is again c=01, n=001.
- Reset mid-operation: `rst`=0 in the DEAL cycle of card 3 -> next edge all outputs 0; no card 3 ever visible.
- Wrap/saturation: DEAL_PERIOD=2, run 300 deals:
  - card 15 equals card 0 (c=01, n=001)
  - deal_cnt sticks at 255
  - numbers always 1..5, colours always 1..3
- With `DEALER_LFSR_EN` and SEED=8'hA5:
  - all dealt cards are in the legal ranges
  - the first 3 cards match a bench LFSR model cycle for cycle
  - `stop` then restart reproduces the same first card

Source files
------------

// File: rtl/card_dealer_if.sv
// Bus between game control and the card dealer: control levels in, card table out.
// The master side is game control; the slave side is the dealer.
interface card_dealer_if;
    logic       start;
    logic       stop;
    logic       hold;
    logic [1:0] c1;
    logic [2:0] n1;
    logic [1:0] c2;
    logic [2:0] n2;
    logic       new_card;
    logic       slot;
    logic [7:0] deal_cnt;

    modport master (
        output start, stop, hold,
        input  c1, n1, c2, n2, new_card, slot, deal_cnt
    );

    modport slave (
        input  start, stop, hold,
        output c1, n1, c2, n2, new_card, slot, deal_cnt
    );
endinterface

// File: rtl/card_dealer.sv
// Two-slot card source: deals into alternating slots every DEAL_PERIOD cycles, pausable.
// Define DEALER_LFSR_EN to draw cards from an 8-bit LFSR instead of the mod-3/mod-5 sequence.
module card_dealer #(
    parameter int unsigned DEAL_PERIOD = 15,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input logic          clk,
    input logic          rst,
    card_dealer_if.slave bus
);
    if (DEAL_PERIOD < 2 || DEAL_PERIOD > 255) begin : g_bad_period
        $error("card_dealer: DEAL_PERIOD must be in 2..255");
    end
    if (SEED == 8'h00) begin : g_bad_seed
        $error("card_dealer: SEED must be non-zero");
    end

    localparam logic [7:0] RELOAD = 8'(DEAL_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DEAL, WAIT, PAUSE} state_t;

    state_t     state, state_nx;
    logic [7:0] timer, timer_nx;
    logic       do_deal;
    logic [3:0] k;
    logic       next_slot;
    logic [1:0] colour;
    logic [2:0] number;

    logic [1:0] c1_q, c2_q;
    logic [2:0] n1_q, n2_q;
    logic       new_card_q;
    logic       slot_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    // Releasing hold is itself a countdown step, so H held cycles delay the deal by exactly H.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        do_deal  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nx = DEAL;
            end
            DEAL: begin
                do_deal  = 1'b1;
                timer_nx = RELOAD;
                state_nx = WAIT;
            end
            WAIT, PAUSE: begin
                if (bus.hold) begin
                    state_nx = PAUSE;
                end else if (timer <= 8'd1) begin
                    timer_nx = '0;
                    state_nx = DEAL;
                end else begin
                    timer_nx = timer - 8'd1;
                    state_nx = WAIT;
                end
            end
        endcase
        if (bus.stop) begin
            state_nx = IDLE;
            timer_nx = '0;
            do_deal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k          <= '0;
            next_slot  <= 1'b0;
            c1_q       <= '0;
            n1_q       <= '0;
            c2_q       <= '0;
            n2_q       <= '0;
            new_card_q <= 1'b0;
            slot_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            new_card_q <= do_deal;
            if (bus.stop) begin
                k         <= '0;
                next_slot <= 1'b0;
                c1_q      <= '0;
                n1_q      <= '0;
                c2_q      <= '0;
                n2_q      <= '0;
                slot_q    <= 1'b0;
                cnt_q     <= '0;
            end else if (do_deal) begin
                if (next_slot) begin
                    c2_q <= colour;
                    n2_q <= number;
                end else begin
                    c1_q <= colour;
                    n1_q <= number;
                end
                slot_q    <= next_slot;
                next_slot <= ~next_slot;
                k         <= (k == 4'd14) ? '0 : k + 4'd1;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end
        end
    end

`ifdef DEALER_LFSR_EN
    logic [7:0] lfsr;

    // Taps 8,6,5,4; the register idles in IDLE so a restart replays the same sequence.
    always_ff @(posedge clk) begin
        if (!rst || bus.stop) begin
            lfsr <= SEED;
        end else if (state != IDLE) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        colour = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
        number = (lfsr[4:2] < 3'd5) ? lfsr[4:2] + 3'd1 : lfsr[4:2] - 3'd4;
    end
`else
    always_comb begin
        colour = 2'(k % 4'd3) + 2'd1;
        number = 3'(k % 4'd5) + 3'd1;
    end
`endif

    assign bus.c1       = c1_q;
    assign bus.n1       = n1_q;
    assign bus.c2       = c2_q;
    assign bus.n2       = n2_q;
    assign bus.new_card = new_card_q;
    assign bus.slot     = slot_q;
    assign bus.deal_cnt = cnt_q;
endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed steps with a queue of expected deals per instance.
// Build with +define+DEALER_LFSR_EN to check the LFSR card source instead.
module tb_card_dealer;
    localparam int unsigned P    = 15;
    localparam int unsigned PF   = 2;
    localparam logic [7:0]  SEED = 8'hA5;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    card_dealer_if bm ();
    card_dealer_if bf ();

    card_dealer #(.DEAL_PERIOD(P), .SEED(SEED)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bm.slave)
    );

    card_dealer #(.DEAL_PERIOD(PF), .SEED(SEED)) u_fast (
        .clk (clk),
        .rst (rst_f),
        .bus (bf.slave)
    );

    typedef struct {
        int unsigned edge_no;
        logic [1:0]  c1;
        logic [2:0]  n1;
        logic [1:0]  c2;
        logic [2:0]  n2;
        logic        slot;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q_m[$];
    exp_t        q_f[$];
    exp_t        tbl[2];
    int unsigned cyc   = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef DEALER_LFSR_EN
    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int unsigned n);
        logic [7:0] l;
        l = s;
        for (int unsigned i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction
`endif

    function automatic logic nc(input int w);
        return (w == 1) ? bf.new_card : bm.new_card;
    endfunction

    function automatic exp_t obs(input int w);
        exp_t o;
        o.edge_no = cyc;
        if (w == 1) begin
            o.c1 = bf.c1; o.n1 = bf.n1; o.c2 = bf.c2; o.n2 = bf.n2;
            o.slot = bf.slot; o.cnt = bf.deal_cnt;
        end else begin
            o.c1 = bm.c1; o.n1 = bm.n1; o.c2 = bm.c2; o.n2 = bm.n2;
            o.slot = bm.slot; o.cnt = bm.deal_cnt;
        end
        return o;
    endfunction

    task automatic clear_table(input int w);
        tbl[w].c1 = '0; tbl[w].n1 = '0; tbl[w].c2 = '0; tbl[w].n2 = '0;
        tbl[w].slot = 1'b0; tbl[w].cnt = '0; tbl[w].edge_no = 0;
    endtask

    // Deal j (counted from start) lands at edge e; t0 is the edge that saw start.
    task automatic push_deal(input int w, input int unsigned j, input int unsigned e,
                             input int unsigned t0);
        logic [1:0] c;
        logic [2:0] n;
`ifdef DEALER_LFSR_EN
        logic [7:0] l;
        l = lfsr_adv(SEED, e - t0 - 1);
        c = (l[1:0] == 2'b00) ? 2'b01 : l[1:0];
        n = (l[4:2] < 3'd5) ? l[4:2] + 3'd1 : l[4:2] - 3'd4;
`else
        int unsigned kk;
        kk = j % 15;
        c = 2'(kk % 3 + 1);
        n = 3'(kk % 5 + 1);
`endif
        if (j % 2 == 0) begin
            tbl[w].c1 = c; tbl[w].n1 = n;
        end else begin
            tbl[w].c2 = c; tbl[w].n2 = n;
        end
        tbl[w].slot    = 1'(j % 2);
        tbl[w].cnt     = (j + 1 > 255) ? 8'hFF : 8'(j + 1);
        tbl[w].edge_no = e;
        if (w == 1) q_f.push_back(tbl[w]);
        else q_m.push_back(tbl[w]);
    endtask

    task automatic expect_deal(input int w, input string tag);
        int unsigned n;
        exp_t        x;
        exp_t        o;
        n = 0;
        do begin
            tick();
            n++;
        end while (!nc(w) && n < 64);
        chk({tag, "/pulse"}, 32'(nc(w)), 32'd1);
        if ((w == 1) ? (q_f.size() == 0) : (q_m.size() == 0)) begin
            chk({tag, "/queue"}, 32'd0, 32'd1);
        end else begin
            x = (w == 1) ? q_f.pop_front() : q_m.pop_front();
            o = obs(w);
            chk({tag, "/edge"}, o.edge_no, x.edge_no);
            chk({tag, "/card1"}, 32'({o.c1, o.n1}), 32'({x.c1, x.n1}));
            chk({tag, "/card2"}, 32'({o.c2, o.n2}), 32'({x.c2, x.n2}));
            chk({tag, "/slot"}, 32'(o.slot), 32'(x.slot));
            chk({tag, "/cnt"}, 32'(o.cnt), 32'(x.cnt));
            if (w == 1) begin
                chk({tag, "/range"}, 32'(o.slot ? (o.c2 inside {[1:3]} && o.n2 inside {[1:5]})
                                               : (o.c1 inside {[1:3]} && o.n1 inside {[1:5]})),
                    32'd1);
            end
        end
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "/c1n1"}, 32'({bm.c1, bm.n1}), 32'd0);
        chk({tag, "/c2n2"}, 32'({bm.c2, bm.n2}), 32'd0);
        chk({tag, "/new_card"}, 32'(bm.new_card), 32'd0);
        chk({tag, "/slot"}, 32'(bm.slot), 32'd0);
        chk({tag, "/cnt"}, 32'(bm.deal_cnt), 32'd0);
    endtask

    initial begin
        int unsigned t;
        int unsigned t2;
        int unsigned tf;
        int unsigned pulses;

        bm.start = 1'b0; bm.stop = 1'b0; bm.hold = 1'b0;
        bf.start = 1'b0; bf.stop = 1'b0; bf.hold = 1'b0;
        clear_table(0);
        clear_table(1);

        // Reset state, then idle without start.
        repeat (3) tick();
        chk_empty("reset");
        chk("reset/fast_cnt", 32'(bf.deal_cnt), 32'd0);
        rst = 1'b1; rst_f = 1'b1;
        repeat (3) tick();
        chk_empty("idle");

        // Start; deal 0 at t+1, hold over edges t+6..t+15 pushes deal 1 to t+26.
        bm.start = 1'b1;
        tick();
        t = cyc;
        bm.start = 1'b0;
        push_deal(0, 0, t + 1, t);
        push_deal(0, 1, t + 26, t);
        push_deal(0, 2, t + 41, t);
        expect_deal(0, "deal0");
        repeat (4) tick();
        bm.hold = 1'b1;
        pulses = 0;
        repeat (10) begin
            tick();
            if (bm.new_card) pulses++;
        end
        bm.hold = 1'b0;
        chk("hold/no_pulse", pulses, 32'd0);
        expect_deal(0, "deal1");
        expect_deal(0, "deal2");

        // Hold rises on the edge where deal 3 falls due: deferred by the 3 held cycles.
        push_deal(0, 3, t + 59, t);
        repeat (13) tick();
        bm.hold = 1'b1;
        pulses = 0;
        repeat (3) begin
            tick();
            if (bm.new_card) pulses++;
        end
        bm.hold = 1'b0;
        chk("defer/no_pulse", pulses, 32'd0);
        expect_deal(0, "deal3");

        // Stop beats start mid-WAIT; restart replays the first card.
        repeat (4) tick();
        bm.stop = 1'b1; bm.start = 1'b1;
        tick();
        chk_empty("stop");
        clear_table(0);
        bm.stop = 1'b0;
        tick();
        t2 = cyc;
        bm.start = 1'b0;
        push_deal(0, 0, t2 + 1, t2);
        push_deal(0, 1, t2 + 16, t2);
        push_deal(0, 2, t2 + 31, t2);
        expect_deal(0, "restart0");
        expect_deal(0, "restart1");
        expect_deal(0, "restart2");

        // Reset during the DEAL cycle of card 3: nothing of card 3 may appear.
        repeat (14) tick();
        rst = 1'b0;
        tick();
        chk_empty("rst_mid");
        tick();
        rst = 1'b1;
        pulses = 0;
        repeat (20) begin
            tick();
            if (bm.new_card || bm.c1 != 2'b00 || bm.c2 != 2'b00) pulses++;
        end
        chk("rst_mid/quiet", pulses, 32'd0);

        // Fast instance: 300 back-to-back deals, k wrap and deal_cnt saturation.
        bf.start = 1'b1;
        tick();
        tf = cyc;
        bf.start = 1'b0;
        for (int unsigned j = 0; j < 300; j++) push_deal(1, j, tf + 1 + PF * j, tf);
        for (int unsigned j = 0; j < 300; j++) expect_deal(1, $sformatf("fast%0d", j));

        chk("queues_drained", 32'(q_m.size() + q_f.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
